// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one shared resource: registered one-hot grant with a bounded
// tenure, released on done, withdrawal or hold limit, followed by one turnaround cycle.
module rr_resource_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    cand;
    logic               limit;
    logic               withdrawn;

    // (base + off) mod N_REQ; works for non-power-of-two N_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return ID_W'(sum);
    endfunction

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = wrap_add(ptr_q, i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign limit     = (hold_q == HOLD_W'(MAX_HOLD));
    assign withdrawn = !req[gnt_id_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d    = N_REQ'(1) << win_idx;
                    gnt_id_d = win_idx;
                    busy_d   = 1'b1;
                    hold_d   = HOLD_W'(1);
                    ptr_d    = wrap_add(win_idx, 1);
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                hold_d = hold_q + HOLD_W'(1);
                if (done || withdrawn || limit) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    // Only a pure hold-limit expiry is reported as a timeout.
                    timeout_d = limit && !done && !withdrawn;
                    state_d   = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed bench for rr_resource_arbiter (N_REQ=4, MAX_HOLD=16); inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_rr_resource_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_resource_arbiter #(
        .N_REQ   (4),
        .MAX_HOLD(16),
        .ID_W    (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] id);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(g));
        check_eq({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
        check_eq({tag, ".busy"}, 32'(busy), 32'(g != 4'b0));
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0;
        done = 1'b0;

        // Reset then single request
        tick();
        tick();
        rst = 1'b0;
        check_grant("reset", 4'b0000, 2'd0);
        check_eq("reset.timeout", 32'(timeout), 32'd0);
        req = 4'b0100;
        tick();
        check_grant("single.issue", 4'b0100, 2'd2);
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check_grant("single.release", 4'b0000, 2'd2);
        check_eq("single.release.timeout", 32'(timeout), 32'd0);
        tick();
        check_eq("single.gap", 32'(gnt), 32'd0);
        tick();
        check_grant("single.regrant", 4'b0100, 2'd2);
        req = 4'b0000;
        tick();
        check_grant("single.withdraw", 4'b0000, 2'd2);
        tick();
        tick();

        // Rotation from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_grant("rot.issue", 4'(1 << (k % 4)), 2'(k % 4));
            tick();
            check_eq("rot.hold", 32'(gnt), 32'(1 << (k % 4)));
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            check_eq("rot.release", 32'(gnt), 32'd0);
            check_eq("rot.timeout", 32'(timeout), 32'd0);
            tick();
            check_eq("rot.gap", 32'(gnt), 32'd0);
        end

        // Hold limit
        req = 4'b0001;
        tick();
        check_grant("limit.issue", 4'b0001, 2'd0);
        for (int k = 2; k <= 16; k++) begin
            tick();
            check_eq("limit.held", 32'(gnt), 32'd1);
            check_eq("limit.no_to", 32'(timeout), 32'd0);
        end
        tick();
        check_eq("limit.release", 32'(gnt), 32'd0);
        check_eq("limit.timeout", 32'(timeout), 32'd1);
        tick();
        check_eq("limit.pulse_end", 32'(timeout), 32'd0);
        tick();
        check_grant("limit.regrant", 4'b0001, 2'd0);

        // done in the 16th grant cycle
        for (int k = 2; k <= 16; k++) tick();
        check_eq("done_limit.held", 32'(gnt), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_eq("done_limit.release", 32'(gnt), 32'd0);
        check_eq("done_limit.timeout", 32'(timeout), 32'd0);
        tick();
        tick();
        check_grant("wd_limit.issue", 4'b0001, 2'd0);

        // Withdrawal in the 16th grant cycle
        for (int k = 2; k <= 16; k++) tick();
        req = 4'b0000;
        tick();
        check_eq("wd_limit.release", 32'(gnt), 32'd0);
        check_eq("wd_limit.timeout", 32'(timeout), 32'd0);
        tick();

        // Withdrawal, pointer is at 1
        req = 4'b1010;
        tick();
        check_grant("wd.issue", 4'b0010, 2'd1);
        tick();
        tick();
        tick();
        req = 4'b1000;
        tick();
        check_grant("wd.release", 4'b0000, 2'd1);
        check_eq("wd.timeout", 32'(timeout), 32'd0);
        tick();
        tick();
        check_grant("wd.next", 4'b1000, 2'd3);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0100;
        tick();
        tick();
        check_grant("mid.issue", 4'b0100, 2'd2);
        tick();

        // Reset mid-grant
        rst = 1'b1;
        tick();
        check_grant("mid.reset", 4'b0000, 2'd0);
        check_eq("mid.reset.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check_grant("mid.after", 4'b0001, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
